// File: rtl/mod_exp_ctrl_pkg.sv
// mod_exp_ctrl_pkg: operand width, controller states and constants shared by the modexp slice.
`ifndef BITS
`define BITS 8
`endif
package mod_exp_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, TO_MONT, INIT, SQ, MUL, FROM_MONT, DONE} state_t;
  localparam logic [`BITS-1:0] ONE = `BITS'(1);
endpackage

// File: rtl/mod_exp_ctrl_montgomery_mult.sv
// montgomery_mult: single-cycle combinational Montgomery product p = a*b*R^-1 mod n, R = 2^W.
module montgomery_mult #(
  parameter int W = `BITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  input  logic [W-1:0] n_prime,
  output logic [W-1:0] p
);
  logic [2*W:0] t, mn, s;
  logic [W-1:0] m;
  logic [W:0] u;
  always_comb begin
    t = (2*W+1)'(a) * (2*W+1)'(b);
    m = t[W-1:0] * n_prime;
    mn = (2*W+1)'(m) * (2*W+1)'(n);
    s = t + mn;
    u = s[2*W:W];
    p = u >= {1'b0, n} ? W'(u - {1'b0, n}) : u[W-1:0];
  end
endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: P = M^E mod N by left-to-right square-and-multiply over one Montgomery multiplier.
// Define MODEXP_SKIP_LEADING_ZEROS_EN to start the bit loop at the highest set bit of E.
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int EXP_BITS = `BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [`BITS-1:0]    M,
  input  logic [EXP_BITS-1:0] E,
  input  logic [`BITS-1:0]    N,
  input  logic [`BITS-1:0]    N_prime,
  input  logic [`BITS-1:0]    R2,
  output logic                busy,
  output logic                done,
  output logic [`BITS-1:0]    P
);
  localparam int CW = $clog2(EXP_BITS) + 1;
  state_t state;
  logic [`BITS-1:0] m_r, n_r, np_r, r2_r, mbar, xbar, mm_a, mm_b, mm_p;
  logic [EXP_BITS-1:0] e_r, e_sh;
  logic [CW-1:0] i;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  function automatic logic [CW-1:0] msb(input logic [EXP_BITS-1:0] v);
    msb = '0;
    for (int k = 0; k < EXP_BITS; k++) if (v[k]) msb = CW'(k);
  endfunction
`endif
  assign e_sh = e_r >> i;
  always_comb begin
    mm_a = state == TO_MONT ? m_r : state == INIT ? ONE :
           (state == SQ || state == MUL || state == FROM_MONT) ? xbar : '0;
    mm_b = (state == TO_MONT || state == INIT) ? r2_r : state == SQ ? xbar :
           state == MUL ? mbar : state == FROM_MONT ? ONE : '0;
  end
  montgomery_mult #(.W(`BITS)) u_mm (.a(mm_a), .b(mm_b), .n(n_r), .n_prime(np_r), .p(mm_p));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      P <= '0;
      m_r <= '0;
      e_r <= '0;
      n_r <= '0;
      np_r <= '0;
      r2_r <= '0;
      mbar <= '0;
      xbar <= '0;
      i <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m_r <= M;
          e_r <= E;
          n_r <= N;
          np_r <= N_prime;
          r2_r <= R2;
          busy <= 1'b1;
          state <= TO_MONT;
        end
        TO_MONT: begin
          mbar <= mm_p;
          state <= INIT;
        end
        INIT: begin
          xbar <= mm_p;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          i <= msb(e_r);
          state <= e_r == '0 ? FROM_MONT : SQ;
`else
          i <= CW'(EXP_BITS - 1);
          state <= SQ;
`endif
        end
        SQ, MUL: begin
          xbar <= mm_p;
          // a set bit gets its multiply before the index advances
          if (state == SQ && e_sh[0]) state <= MUL;
          else if (i == '0) state <= FROM_MONT;
          else begin
            i <= i - 1'b1;
            state <= SQ;
          end
        end
        FROM_MONT: begin
          P <= mm_p;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
